// File: rtl/filt_fifo_if.sv
// Handshake/bus bundle between the filter stage, register block and filt_fifo.
interface filt_fifo_if #(
  parameter int AW = 4
);
  logic [31:0] filt_data_out;
  logic        filt_data_update;
  logic        reg_fifoen;
  logic [AW-1:0] reg_fifolvl;
  logic        rd_req;
  logic        ovf_clr;
  logic [31:0] rd_data;
  logic [AW:0] fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_ovf;
  logic        fifo_int;

  modport master (
    output filt_data_out, filt_data_update, reg_fifoen, reg_fifolvl, rd_req, ovf_clr,
    input  rd_data, fifo_cnt, fifo_empty, fifo_full, fifo_ovf, fifo_int
  );

  modport slave (
    input  filt_data_out, filt_data_update, reg_fifoen, reg_fifolvl, rd_req, ovf_clr,
    output rd_data, fifo_cnt, fifo_empty, fifo_full, fifo_ovf, fifo_int
  );
endinterface

// File: rtl/filt_fifo.sv
// First-word-fall-through FIFO for filter output words with sticky overflow and level interrupt.
// Build option: define FILT_FIFO_OVERWRITE_EN to make an overflowing write replace the oldest word.
module filt_fifo #(
  parameter int AW = 4
) (
  input logic        SYSCLK,
  input logic        SYSRST,
  filt_fifo_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, cnt_next, lvl_thr;
  logic          ovf, irq;
  logic          wr_en, pop, full, empty, ovf_evt, do_wr, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign wr_en   = bus.filt_data_update && bus.reg_fifoen;
  assign pop     = bus.rd_req && !empty;
  assign ovf_evt = wr_en && full && !pop;
  assign lvl_thr = {1'b0, bus.reg_fifolvl} + (AW+1)'(1);

`ifdef FILT_FIFO_OVERWRITE_EN
  // Overflow drops the oldest word: treated as a write plus an implicit pop.
  assign do_wr  = wr_en;
  assign do_pop = pop || ovf_evt;
`else
  assign do_wr  = wr_en && !ovf_evt;
  assign do_pop = pop;
`endif

  always_comb begin
    cnt_next = cnt;
    case ({do_wr, do_pop})
      2'b10:   cnt_next = cnt + (AW+1)'(1);
      2'b01:   cnt_next = cnt - (AW+1)'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (do_wr) mem[wr_ptr] <= bus.filt_data_out;
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST || !bus.reg_fifoen) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_next;
      if (ovf_evt)          ovf <= 1'b1;
      else if (bus.ovf_clr) ovf <= 1'b0;
      irq <= (cnt_next >= lvl_thr);
    end
  end

  assign bus.rd_data    = empty ? '0 : mem[rd_ptr];
  assign bus.fifo_cnt   = cnt;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.fifo_ovf   = ovf;
  assign bus.fifo_int   = irq;
endmodule

// File: doc/filt_fifo.md
FILT_FIFO -- requirements
Module: filt_fifo

Interface
REQ-001 Parameter AW, 4, address width; FIFO depth SHALL be 2^AW words (16 at default).
REQ-002 SYSCLK  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 SYSRST  input  1  reset, synchronous, active-high.
REQ-004 filt_data_out  input  32  filter data word from the filter stage.
REQ-005 filt_data_update  input  1  one-SYSCLK write strobe from the filter stage.
REQ-006 reg_fifoen  input  1  FIFO enable; 0 SHALL hold the FIFO flushed.
REQ-007 reg_fifolvl  input  AW  interrupt threshold field; threshold = reg_fifolvl+1 words.
REQ-008 rd_req  input  1  one-cycle read/pop request.
REQ-009 ovf_clr  input  1  one-cycle clear of the sticky overflow flag.
REQ-010 rd_data  output  32  head word, first-word-fall-through; 32'h0 while empty.
REQ-011 fifo_cnt  output  AW+1  number of stored words, 0..2^AW.
REQ-012 fifo_empty  output  1  fifo_cnt == 0.
REQ-013 fifo_full  output  1  fifo_cnt == 2^AW.
REQ-014 fifo_ovf  output  1  sticky overflow flag.
REQ-015 fifo_int  output  1  registered level interrupt.

Function
REQ-016 Write SHALL occur when filt_data_update && reg_fifoen; word stored at wr_ptr, wr_ptr increments modulo 2^AW.
REQ-017 Pop SHALL occur when rd_req && !fifo_empty; rd_ptr increments modulo 2^AW; rd_req while empty SHALL be ignored, no state change.
REQ-018 Latency: write in cycle N SHALL update fifo_cnt, fifo_empty, rd_data (if previously empty) in cycle N+1; pop in cycle N SHALL present the next word in N+1.
REQ-019 Simultaneous write and pop with 0 < fifo_cnt < 2^AW SHALL leave fifo_cnt unchanged.
REQ-020 Simultaneous write and pop when full SHALL accept both, fifo_cnt stays 2^AW, fifo_ovf unchanged.
REQ-021 Write while empty with rd_req SHALL store the word; the pop SHALL be ignored.
REQ-022 Write while full without pop is an overflow: fifo_ovf SHALL set in N+1; data handling per REQ-029.
REQ-023 ovf_clr SHALL clear fifo_ovf in N+1; overflow and ovf_clr in the same cycle SHALL leave fifo_ovf set.
REQ-024 fifo_int SHALL be registered: fifo_int(N+1) = reg_fifoen && (fifo_cnt_next >= reg_fifolvl+1).
REQ-025 reg_fifoen = 0 SHALL, next cycle, zero both pointers, fifo_cnt, fifo_ovf, fifo_int; writes SHALL be dropped without flagging overflow.
REQ-026 Memory contents need not be reset; rd_data SHALL be forced to 0 while empty.

Reset
REQ-027 SYSRST = 1 at a rising SYSCLK edge SHALL set pointers and fifo_cnt to 0, fifo_empty = 1, fifo_full = 0, fifo_ovf = 0, fifo_int = 0, rd_data = 0.
REQ-028 Reset asserted mid-operation SHALL override all concurrent writes, pops and ovf_clr in that cycle.

Configuration
REQ-029 Macro FILT_FIFO_OVERWRITE_EN: defined -> overflowing write SHALL discard the oldest word (rd_ptr and wr_ptr both advance, new word stored, fifo_cnt stays 2^AW); undefined -> overflowing write SHALL be discarded, FIFO contents and pointers unchanged; fifo_ovf sets in both builds.

Verification
REQ-030 Reset, reg_fifoen=1, write 0x11111111 then 0x22222222 -> fifo_cnt=2, rd_data=0x11111111; rd_req -> rd_data=0x22222222, fifo_cnt=1.
REQ-031 reg_fifolvl=3, write 3 words -> fifo_int=0; 4th write -> fifo_int=1 next cycle; one pop -> fifo_int=0.
REQ-032 Fill 16 words 0..15, 17th write 0xDEADBEEF -> fifo_full=1, fifo_ovf=1; undefined macro: rd_data=0, drained sequence 0..15; defined macro: rd_data=1, drained sequence 1..15, 0xDEADBEEF.
REQ-033 Full FIFO, write and rd_req same cycle -> fifo_cnt=16, fifo_ovf=0, last drained word is the new one; ovf_clr coincident with overflow -> fifo_ovf=1.
REQ-034 5 words stored, reg_fifoen=0 one cycle -> fifo_cnt=0, fifo_empty=1, rd_data=0; SYSRST pulse during simultaneous write/pop -> all outputs at reset values.
